// File: rtl/commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_fifo
// Description : Classifies each committed CPU cycle as one retired instruction,
//               stamps it and buffers it in a show-ahead FIFO until HALT.
// Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              pc,
    input  logic                     reg_write,
    input  logic [3:0]               write_reg,
    input  logic [15:0]              write_data,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [15:0]              mem_addr,
    input  logic [15:0]              mem_data,
    input  logic                     hlt,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [2:0]               rd_kind,
    output logic [15:0]              rd_pc,
    output logic [3:0]               rd_reg,
    output logic [15:0]              rd_value,
    output logic [15:0]              rd_addr,
    output logic [CNT_W-1:0]         rd_inum,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     halted,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         inst_count
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH_CNT = (c_PTR_W + 1)'(DEPTH);

    localparam logic [2:0] c_KIND_NOP   = 3'd0;
    localparam logic [2:0] c_KIND_REG   = 3'd1;
    localparam logic [2:0] c_KIND_LOAD  = 3'd2;
    localparam logic [2:0] c_KIND_STORE = 3'd3;
    localparam logic [2:0] c_KIND_HALT  = 3'd4;

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_PTR_W-1:0]  r_wrPtr;
    logic [c_PTR_W-1:0]  r_rdPtr;
    logic [c_PTR_W:0]    r_count;
    logic                r_overflow;
    logic [CNT_W-1:0]    r_cycleCount;
    logic [CNT_W-1:0]    r_instCount;

    logic [2:0]          r_memKind  [DEPTH];
    logic [15:0]         r_memPc    [DEPTH];
    logic [3:0]          r_memReg   [DEPTH];
    logic [15:0]         r_memValue [DEPTH];
    logic [15:0]         r_memAddr  [DEPTH];
    logic [CNT_W-1:0]    r_memInum  [DEPTH];

    logic [2:0]          w_kind;
    logic [3:0]          w_reg;
    logic [15:0]         w_value;
    logic [15:0]         w_addr;
    logic                w_run;
    logic                w_full;
    logic                w_pop;
    logic                w_write;
    logic                w_drop;

    // A load is also a register write, so it must be tested before plain REG.
    always_comb begin
        w_kind  = c_KIND_NOP;
        w_reg   = 4'd0;
        w_value = 16'd0;
        w_addr  = 16'd0;
        if (reg_write && mem_read) begin
            w_kind  = c_KIND_LOAD;
            w_reg   = write_reg;
            w_value = write_data;
            w_addr  = mem_addr;
        end else if (reg_write) begin
            w_kind  = c_KIND_REG;
            w_reg   = write_reg;
            w_value = write_data;
        end else if (hlt) begin
            w_kind  = c_KIND_HALT;
        end else if (mem_write) begin
            w_kind  = c_KIND_STORE;
            w_value = mem_data;
            w_addr  = mem_addr;
        end
    end

    assign w_run   = (r_state == S_RUN);
    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_pop   = rd_en && (r_count != '0);
    assign w_write = w_run && (!w_full || w_pop);
    assign w_drop  = w_run && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_memKind[r_wrPtr]  <= w_kind;
            r_memPc[r_wrPtr]    <= pc;
            r_memReg[r_wrPtr]   <= w_reg;
            r_memValue[r_wrPtr] <= w_value;
            r_memAddr[r_wrPtr]  <= w_addr;
            r_memInum[r_wrPtr]  <= r_instCount;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RUN;
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_cycleCount <= '0;
            r_instCount  <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_run) begin
                r_cycleCount <= r_cycleCount + 1'b1;
                r_instCount  <= r_instCount + 1'b1;
                if (w_kind == c_KIND_HALT) begin
                    r_state <= S_HALTED;
                end
            end
        end
    end

    // Show-ahead read port: the head entry is visible without a pop.
    assign rd_kind     = r_memKind[r_rdPtr];
    assign rd_pc       = r_memPc[r_rdPtr];
    assign rd_reg      = r_memReg[r_rdPtr];
    assign rd_value    = r_memValue[r_rdPtr];
    assign rd_addr     = r_memAddr[r_rdPtr];
    assign rd_inum     = r_memInum[r_rdPtr];

    assign count       = r_count;
    assign full        = w_full;
    assign empty       = (r_count == '0);
    assign rd_valid    = (r_count != '0);
    assign overflow    = r_overflow;
    assign halted      = (r_state == S_HALTED);
    assign cycle_count = r_cycleCount;
    assign inst_count  = r_instCount;

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_fifo
// Description : Directed bench for commit_trace_fifo with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        reg_write = 1'b0;
    logic [3:0]  write_reg = '0;
    logic [15:0] write_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_data = '0;
    logic        hlt = 1'b0;
    logic        rd_en = 1'b0;

    logic             rd_valid;
    logic [2:0]       rd_kind;
    logic [15:0]      rd_pc;
    logic [3:0]       rd_reg;
    logic [15:0]      rd_value;
    logic [15:0]      rd_addr;
    logic [CNT_W-1:0] rd_inum;
    logic [4:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] inst_count;

    int tests = 0;
    int fails = 0;

    commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .reg_write(reg_write),
        .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .hlt(hlt), .rd_en(rd_en), .rd_valid(rd_valid), .rd_kind(rd_kind),
        .rd_pc(rd_pc), .rd_reg(rd_reg), .rd_value(rd_value), .rd_addr(rd_addr),
        .rd_inum(rd_inum), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .halted(halted), .cycle_count(cycle_count),
        .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0]  kind;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] value;
        logic [15:0] addr;
        logic [31:0] inum;
    } ent_t;

    ent_t        mq[$];
    bit          mHalted = 0;
    bit          mOvf = 0;
    logic [31:0] mCyc = 0;
    logic [31:0] mInst = 0;
    ent_t        mEv;
    int          mSize;
    bit          mPop;

    function automatic ent_t classify();
        ent_t e;
        e.pc = pc; e.rg = 0; e.value = 0; e.addr = 0; e.inum = 0;
        if (reg_write && mem_read) begin
            e.kind = 2; e.rg = write_reg; e.value = write_data; e.addr = mem_addr;
        end else if (reg_write) begin
            e.kind = 1; e.rg = write_reg; e.value = write_data;
        end else if (hlt) begin
            e.kind = 4;
        end else if (mem_write) begin
            e.kind = 3; e.value = mem_data; e.addr = mem_addr;
        end else begin
            e.kind = 0;
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mHalted = 0; mOvf = 0; mCyc = 0; mInst = 0;
        end else begin
            mSize = mq.size();
            mPop  = rd_en && (mSize > 0);
            if (mPop) void'(mq.pop_front());
            if (!mHalted) begin
                mEv = classify();
                mEv.inum = mInst;
                if (mSize == DEPTH && !mPop) mOvf = 1;
                else mq.push_back(mEv);
                mInst = mInst + 1;
                mCyc  = mCyc + 1;
                if (mEv.kind == 4) mHalted = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("count",    64'(count),       64'(mq.size()));
            check("empty",    64'(empty),       64'(mq.size() == 0));
            check("full",     64'(full),        64'(mq.size() == DEPTH));
            check("rd_valid", 64'(rd_valid),    64'(mq.size() != 0));
            check("overflow", 64'(overflow),    64'(mOvf));
            check("halted",   64'(halted),      64'(mHalted));
            check("cycles",   64'(cycle_count), 64'(mCyc));
            check("insts",    64'(inst_count),  64'(mInst));
            if (mq.size() > 0) begin
                check("rd_kind",  64'(rd_kind),  64'(mq[0].kind));
                check("rd_pc",    64'(rd_pc),    64'(mq[0].pc));
                check("rd_reg",   64'(rd_reg),   64'(mq[0].rg));
                check("rd_value", 64'(rd_value), 64'(mq[0].value));
                check("rd_addr",  64'(rd_addr),  64'(mq[0].addr));
                check("rd_inum",  64'(rd_inum),  64'(mq[0].inum));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic setIdle();
        pc = '0; reg_write = 0; write_reg = '0; write_data = '0; mem_read = 0;
        mem_write = 0; mem_addr = '0; mem_data = '0; hlt = 0; rd_en = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #1;
        check("rst_empty",  64'(empty),    64'd1);
        check("rst_halted", 64'(halted),   64'd0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        setIdle();
        #8;
        check("t1_empty",    64'(empty),       64'd1);
        check("t1_count",    64'(count),       64'd0);
        check("t1_rd_valid", 64'(rd_valid),    64'd0);
        check("t1_halted",   64'(halted),      64'd0);
        check("t1_overflow", 64'(overflow),    64'd0);
        check("t1_cycles",   64'(cycle_count), 64'd0);
        check("t1_insts",    64'(inst_count),  64'd0);

        reg_write = 1; write_reg = 4'd3; write_data = 16'h1234; pc = 16'h0002;
        #4;
        rst_n = 1'b1;
        cycle();
        check("t2_kind",  64'(rd_kind),  64'd1);
        check("t2_reg",   64'(rd_reg),   64'd3);
        check("t2_value", 64'(rd_value), 64'h1234);
        check("t2_inum",  64'(rd_inum),  64'd0);
        setIdle(); rd_en = 1;
        cycle();
        // The pop coincides with a NOP push, so one entry remains.
        check("t2_count", 64'(count),   64'd1);
        check("t2_nop",   64'(rd_kind), 64'd0);
        check("t2_inum1", 64'(rd_inum), 64'd1);

        resetPulse();
        setIdle();
        reg_write = 1; mem_read = 1; mem_addr = 16'h0040; write_data = 16'hBEEF;
        write_reg = 4'd5; pc = 16'h0004; rd_en = 1;
        cycle();
        check("t3_ld_count", 64'(count),    64'd1);
        check("t3_ld_kind",  64'(rd_kind),  64'd2);
        check("t3_ld_addr",  64'(rd_addr),  64'h0040);
        check("t3_ld_value", 64'(rd_value), 64'hBEEF);
        setIdle();
        mem_write = 1; mem_addr = 16'h0010; mem_data = 16'h00AA; pc = 16'h0006; rd_en = 1;
        cycle();
        check("t3_st_kind",  64'(rd_kind),  64'd3);
        check("t3_st_value", 64'(rd_value), 64'h00AA);
        check("t3_st_addr",  64'(rd_addr),  64'h0010);
        check("t3_st_reg",   64'(rd_reg),   64'd0);
        check("t3_st_inum",  64'(rd_inum),  64'd1);

        resetPulse();
        setIdle();
        repeat (16) cycle();
        check("t4_full16", 64'(full),     64'd1);
        check("t4_noovf",  64'(overflow), 64'd0);
        cycle();
        check("t4_full",  64'(full),       64'd1);
        check("t4_count", 64'(count),      64'd16);
        check("t4_ovf",   64'(overflow),   64'd1);
        check("t4_insts", 64'(inst_count), 64'd17);
        check("t4_inum",  64'(rd_inum),    64'd0);

        rd_en = 1;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("t5_count", 64'(count),   64'd16);
            check("t5_inum",  64'(rd_inum), 64'(i));
        end
        check("t5_insts", 64'(inst_count), 64'd21);

        resetPulse();
        setIdle();
        repeat (2) cycle();
        hlt = 1; pc = 16'h0020;
        cycle();
        check("t6_halted", 64'(halted),      64'd1);
        check("t6_count",  64'(count),       64'd3);
        check("t6_insts",  64'(inst_count),  64'd3);
        setIdle();
        hlt = 1; reg_write = 1; write_reg = 4'd7;
        repeat (3) cycle();
        check("t6_frozen_cyc",   64'(cycle_count), 64'd3);
        check("t6_frozen_count", 64'(count),       64'd3);
        setIdle(); rd_en = 1;
        repeat (2) cycle();
        check("t6_halt_kind", 64'(rd_kind), 64'd4);
        check("t6_halt_pc",   64'(rd_pc),   64'h0020);
        check("t6_halt_inum", 64'(rd_inum), 64'd2);
        repeat (2) cycle();
        check("t6_drained", 64'(empty), 64'd1);
        resetPulse();
        rd_en = 0;
        cycle();
        check("t6_rerun_count", 64'(count),      64'd1);
        check("t6_rerun_insts", 64'(inst_count), 64'd1);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
